// File: rtl/drag_pkg.sv
// Shared types and widths for the race game controller.
//   race_state_e : FSM state encoding, also the external 2-bit state code
//   winner_e     : winner codes reported in FINISH
//   SPEED_W      : player speed width
//   POS_W        : player position width
package drag_pkg;

   localparam int unsigned SPEED_W = 8;
   localparam int unsigned POS_W   = 16;

   typedef enum logic [1:0] {
      StIdle      = 2'b00,
      StCountdown = 2'b01,
      StRace      = 2'b10,
      StFinish    = 2'b11
   } race_state_e;

   typedef enum logic [1:0] {
      WinNone = 2'b00,
      WinP1   = 2'b01,
      WinP2   = 2'b10,
      WinTie  = 2'b11
   } winner_e;

endpackage

// File: rtl/player_dyn.sv
// One player's speed/position integrator with saturating arithmetic.
// Ports:
//   clk, reset : clock, asynchronous active-high reset
//   tick       : 1-cycle game tick enable
//   en         : integrate on tick (high only while racing)
//   clr        : synchronous clear of speed and position
//   gas        : synchronized gas key level
//   speed      : current speed (saturates at MAX_SPEED)
//   pos        : current position (saturates at TRACK_LEN)
//   done       : combinational, high on the tick whose next position hits TRACK_LEN
module player_dyn
   import drag_pkg::*;
#(
   parameter int unsigned ACCEL     = 2,
   parameter int unsigned DECEL     = 1,
   parameter int unsigned MAX_SPEED = 200,
   parameter int unsigned TRACK_LEN = 60000
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               tick,
   input  logic               en,
   input  logic               clr,
   input  logic               gas,
   output logic [SPEED_W-1:0] speed,
   output logic [POS_W-1:0]   pos,
   output logic               done
);

   localparam int unsigned SUM_SW = SPEED_W + 1;
   localparam int unsigned SUM_PW = POS_W + 1;
   localparam logic [SPEED_W:0]   ACCEL_C = SUM_SW'(ACCEL);
   localparam logic [SPEED_W:0]   MAX_C   = SUM_SW'(MAX_SPEED);
   localparam logic [SPEED_W-1:0] DECEL_C = SPEED_W'(DECEL);
   localparam logic [POS_W:0]     TRACK_C = SUM_PW'(TRACK_LEN);

   logic [SPEED_W-1:0] speed_q, speed_d;
   logic [POS_W-1:0]   pos_q, pos_d, pos_next;
   logic [SPEED_W:0]   speed_sum;
   logic [POS_W:0]     pos_sum;
   logic               step;

   always_comb begin
      step      = tick & en;
      // One extra bit on both sums so saturation compares never see a wrapped value.
      speed_sum = {1'b0, speed_q} + ACCEL_C;
      pos_sum   = {1'b0, pos_q} + {{(POS_W - SPEED_W + 1){1'b0}}, speed_q};
      pos_next  = (pos_sum >= TRACK_C) ? TRACK_C[POS_W-1:0] : pos_sum[POS_W-1:0];
      pos_d     = pos_q;
      speed_d   = speed_q;
      if (clr) begin
         pos_d   = '0;
         speed_d = '0;
      end else if (step) begin
         // Position integrates the pre-update speed.
         pos_d = pos_next;
         if (gas) begin
            speed_d = (speed_sum >= MAX_C) ? MAX_C[SPEED_W-1:0] : speed_sum[SPEED_W-1:0];
         end else begin
            speed_d = (speed_q > DECEL_C) ? speed_q - DECEL_C : '0;
         end
      end
      done = step & (pos_next == TRACK_C[POS_W-1:0]);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         speed_q <= '0;
         pos_q   <= '0;
      end else begin
         speed_q <= speed_d;
         pos_q   <= pos_d;
      end
   end

   assign speed = speed_q;
   assign pos   = pos_q;

endmodule

// File: rtl/race_ctrl.sv
// Race game controller: key synchronizers, game-tick prescaler, start-light countdown,
// race FSM and winner logic, with two player_dyn integrators.
// Optional feature macro: RACE_FALSE_START_EN (gas during countdown ends the race and
// awards it to the other player).
// Ports:
//   clk, reset                 : 65 MHz pixel clock, asynchronous active-high reset
//   key_start                  : start/restart key level (asynchronous domain)
//   key_gas_p1, key_gas_p2     : gas key levels (asynchronous domain)
//   state                      : 00 IDLE, 01 COUNTDOWN, 10 RACE, 11 FINISH
//   lights                     : thermometer-coded countdown lamps
//   go                         : high while racing
//   speed_p1/p2, pos_p1/p2     : player speed and distance
//   winner                     : 00 none, 01 P1, 10 P2, 11 tie
module race_ctrl
   import drag_pkg::*;
#(
   parameter int unsigned TICK_DIV    = 650000,
   parameter int unsigned COUNT_TICKS = 100,
   parameter int unsigned ACCEL       = 2,
   parameter int unsigned DECEL       = 1,
   parameter int unsigned MAX_SPEED   = 200,
   parameter int unsigned TRACK_LEN   = 60000
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               key_start,
   input  logic               key_gas_p1,
   input  logic               key_gas_p2,
   output logic [1:0]         state,
   output logic [2:0]         lights,
   output logic               go,
   output logic [SPEED_W-1:0] speed_p1,
   output logic [SPEED_W-1:0] speed_p2,
   output logic [POS_W-1:0]   pos_p1,
   output logic [POS_W-1:0]   pos_p2,
   output logic [1:0]         winner
);

   localparam int unsigned DIV_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int unsigned STEP_W = (COUNT_TICKS > 1) ? $clog2(COUNT_TICKS) : 1;

   logic [1:0]        start_sync_q, gas1_sync_q, gas2_sync_q;
   logic              start_prev_q, start_pulse, gas1, gas2;
   logic [DIV_W-1:0]  div_q;
   logic              tick;
   logic [STEP_W-1:0] step_q, step_d;
   logic              step_last;
   race_state_e       state_q, state_d;
   logic [2:0]        lights_q, lights_d;
   winner_e           winner_q, winner_d;
   logic              clr, done1, done2;

   assign start_pulse = start_sync_q[1] & ~start_prev_q;
   assign gas1        = gas1_sync_q[1];
   assign gas2        = gas2_sync_q[1];
   assign tick        = (div_q == DIV_W'(TICK_DIV - 1));
   assign step_last   = (step_q == STEP_W'(COUNT_TICKS - 1));

   // Synchronizers and free-running prescaler.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         start_sync_q <= '0;
         gas1_sync_q  <= '0;
         gas2_sync_q  <= '0;
         start_prev_q <= 1'b0;
         div_q        <= '0;
      end else begin
         start_sync_q <= {start_sync_q[0], key_start};
         gas1_sync_q  <= {gas1_sync_q[0], key_gas_p1};
         gas2_sync_q  <= {gas2_sync_q[0], key_gas_p2};
         start_prev_q <= start_sync_q[1];
         div_q        <= tick ? '0 : div_q + 1'b1;
      end
   end

   always_comb begin
      state_d  = state_q;
      lights_d = lights_q;
      step_d   = step_q;
      winner_d = winner_q;
      clr      = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (start_pulse) begin
               state_d  = StCountdown;
               lights_d = 3'b000;
               step_d   = '0;
            end
         end
         StCountdown: begin
            if (tick) begin
               if (step_last) begin
                  step_d = '0;
                  // The fourth completed period (all lamps lit) starts the race.
                  if (lights_q == 3'b111) begin
                     state_d  = StRace;
                     lights_d = 3'b000;
                  end else begin
                     lights_d = {lights_q[1:0], 1'b1};
                  end
               end else begin
                  step_d = step_q + 1'b1;
               end
            end
`ifdef RACE_FALSE_START_EN
            if (gas1 | gas2) begin
               state_d  = StFinish;
               lights_d = lights_q;
               step_d   = '0;
               winner_d = (gas1 & gas2) ? WinTie : (gas1 ? WinP2 : WinP1);
            end
`endif
         end
         StRace: begin
            if (done1 | done2) begin
               state_d  = StFinish;
               winner_d = (done1 & done2) ? WinTie : (done1 ? WinP1 : WinP2);
            end
         end
         StFinish: begin
            if (start_pulse) begin
               state_d  = StIdle;
               lights_d = 3'b000;
               winner_d = WinNone;
               clr      = 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= StIdle;
         lights_q <= 3'b000;
         step_q   <= '0;
         winner_q <= WinNone;
      end else begin
         state_q  <= state_d;
         lights_q <= lights_d;
         step_q   <= step_d;
         winner_q <= winner_d;
      end
   end

   assign state  = state_q;
   assign lights = lights_q;
   assign go     = (state_q == StRace);
   assign winner = winner_q;

   player_dyn #(
      .ACCEL    (ACCEL),
      .DECEL    (DECEL),
      .MAX_SPEED(MAX_SPEED),
      .TRACK_LEN(TRACK_LEN)
   ) u_p1 (
      .clk  (clk),
      .reset(reset),
      .tick (tick),
      .en   (go),
      .clr  (clr),
      .gas  (gas1),
      .speed(speed_p1),
      .pos  (pos_p1),
      .done (done1)
   );

   player_dyn #(
      .ACCEL    (ACCEL),
      .DECEL    (DECEL),
      .MAX_SPEED(MAX_SPEED),
      .TRACK_LEN(TRACK_LEN)
   ) u_p2 (
      .clk  (clk),
      .reset(reset),
      .tick (tick),
      .en   (go),
      .clr  (clr),
      .gas  (gas2),
      .speed(speed_p2),
      .pos  (pos_p2),
      .done (done2)
   );

endmodule

// File: tb/tb_race_ctrl.sv
// Directed bench for race_ctrl with small game constants (tick every 4 clocks,
// 2 ticks per light step, top speed 6, track length 40).
module tb_race_ctrl;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        key_start = 1'b0;
   logic        key_gas_p1 = 1'b0;
   logic        key_gas_p2 = 1'b0;
   logic [1:0]  state;
   logic [2:0]  lights;
   logic        go;
   logic [7:0]  speed_p1, speed_p2;
   logic [15:0] pos_p1, pos_p2;
   logic [1:0]  winner;

   int unsigned checks = 0;
   int unsigned errors = 0;
   int unsigned edges  = 0;

   always #5 clk = ~clk;

   race_ctrl #(
      .TICK_DIV   (4),
      .COUNT_TICKS(2),
      .ACCEL      (2),
      .DECEL      (1),
      .MAX_SPEED  (6),
      .TRACK_LEN  (40)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .key_start (key_start),
      .key_gas_p1(key_gas_p1),
      .key_gas_p2(key_gas_p2),
      .state     (state),
      .lights    (lights),
      .go        (go),
      .speed_p1  (speed_p1),
      .speed_p2  (speed_p2),
      .pos_p1    (pos_p1),
      .pos_p2    (pos_p2),
      .winner    (winner)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Edges are counted from reset release, so a game tick lands on every 4th edge.
   task automatic clk_edge();
      @(posedge clk);
      edges++;
      #1;
   endtask

   task automatic wait_ticks(input int n);
      int seen = 0;
      while (seen < n) begin
         clk_edge();
         if (edges % 4 == 0) seen++;
      end
   endtask

   // Synchronizer (2 edges) plus edge detect puts the FSM change on the 3rd edge.
   task automatic press_start();
      key_start = 1'b1;
      repeat (3) clk_edge();
      key_start = 1'b0;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_state"}, state, 0);
      check({tag, "_lights"}, lights, 0);
      check({tag, "_go"}, go, 0);
      check({tag, "_spd1"}, speed_p1, 0);
      check({tag, "_spd2"}, speed_p2, 0);
      check({tag, "_pos1"}, pos_p1, 0);
      check({tag, "_pos2"}, pos_p2, 0);
      check({tag, "_win"}, winner, 0);
   endtask

   initial begin
      int spd_up[5]  = '{2, 4, 6, 6, 6};
      int pos_up[5]  = '{0, 2, 6, 12, 18};
      int spd_dn[7]  = '{5, 4, 3, 2, 1, 0, 0};
      int pos_dn[7]  = '{24, 29, 33, 36, 38, 39, 39};
      int n_ticks;

      repeat (2) @(negedge clk);
      reset = 1'b0;
      edges = 0;
      check_all_zero("reset");

      // Countdown timing and race entry.
      press_start();
      check("cd_state", state, 1);
      check("cd_lights0", lights, 0);
      wait_ticks(2);
      check("cd_lights1", lights, 3'b001);
      wait_ticks(2);
      check("cd_lights2", lights, 3'b011);
      wait_ticks(2);
      check("cd_lights3", lights, 3'b111);
      check("cd_go_low", go, 0);
      wait_ticks(2);
      check("race_state", state, 2);
      check("race_go", go, 1);
      check("race_lights", lights, 0);

      // P1 accelerates to saturation, P2 stays idle.
      key_gas_p1 = 1'b1;
      for (int i = 0; i < 5; i++) begin
         wait_ticks(1);
         check($sformatf("acc_spd_t%0d", i + 1), speed_p1, spd_up[i]);
         check($sformatf("acc_pos_t%0d", i + 1), pos_p1, pos_up[i]);
      end
      check("p2_idle_spd", speed_p2, 0);
      check("p2_idle_pos", pos_p2, 0);

      // Coasting down to zero, holding at zero.
      key_gas_p1 = 1'b0;
      for (int i = 0; i < 7; i++) begin
         wait_ticks(1);
         check($sformatf("dec_spd_t%0d", i + 6), speed_p1, spd_dn[i]);
         check($sformatf("dec_pos_t%0d", i + 6), pos_p1, pos_dn[i]);
      end

      // Re-accelerate across the line: 39+2 saturates at 40.
      key_gas_p1 = 1'b1;
      wait_ticks(1);
      check("fin_pre_spd", speed_p1, 2);
      check("fin_pre_pos", pos_p1, 39);
      check("fin_pre_state", state, 2);
      wait_ticks(1);
      check("fin_state", state, 3);
      check("fin_winner", winner, 1);
      check("fin_pos", pos_p1, 40);
      check("fin_spd", speed_p1, 4);
      check("fin_go", go, 0);
      wait_ticks(2);
      check("frz_pos", pos_p1, 40);
      check("frz_spd", speed_p1, 4);
      check("frz_state", state, 3);
      check("frz_winner", winner, 1);
      key_gas_p1 = 1'b0;
      press_start();
      check_all_zero("restart");

      // Identical inputs for both players -> tie on the 9th race tick.
      repeat (3) clk_edge();
      press_start();
      wait_ticks(8);
      check("tie_race", state, 2);
      key_gas_p1 = 1'b1;
      key_gas_p2 = 1'b1;
      n_ticks = 0;
      while (state != 2'b11 && n_ticks < 20) begin
         wait_ticks(1);
         n_ticks++;
      end
      check("tie_state", state, 3);
      check("tie_ticks", n_ticks, 9);
      check("tie_winner", winner, 3);
      check("tie_pos1", pos_p1, 40);
      check("tie_pos2", pos_p2, 40);
      key_gas_p1 = 1'b0;
      key_gas_p2 = 1'b0;
      press_start();
      check("tie_idle", state, 0);

      // start ignored mid-race, then asynchronous reset at pos 18.
      repeat (3) clk_edge();
      press_start();
      wait_ticks(8);
      key_gas_p1 = 1'b1;
      wait_ticks(5);
      check("mid_pos", pos_p1, 18);
      press_start();
      check("ign_start_state", state, 2);
      check("ign_start_pos", pos_p1, 18);
      #2 reset = 1'b1;
      #1 check_all_zero("async");
      key_gas_p1 = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      edges = 0;

      // Gas from P2 while lights show 011.
      press_start();
      wait_ticks(4);
      check("fs_lights", lights, 3'b011);
      key_gas_p2 = 1'b1;
`ifdef RACE_FALSE_START_EN
      repeat (3) clk_edge();
      check("fs_state", state, 3);
      check("fs_winner", winner, 1);
      check("fs_lights_hold", lights, 3'b011);
      check("fs_go", go, 0);
`else
      wait_ticks(2);
      check("nofs_lights3", lights, 3'b111);
      check("nofs_state_cd", state, 1);
      wait_ticks(2);
      check("nofs_state", state, 2);
      check("nofs_go", go, 1);
      check("nofs_lights", lights, 0);
      check("nofs_winner", winner, 0);
      check("nofs_spd2", speed_p2, 0);
`endif
      key_gas_p2 = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
